// File: rtl/sha1_ctrl.sv
// SHA-1 message controller: buffers 32-bit words into 512-bit blocks, applies
// padding and length, and sequences an external compression core.
module sha1_ctrl (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_nbytes,
    output logic         core_start,
    output logic [511:0] core_block,
    output logic [159:0] core_hin,
    input  logic         core_done,
    input  logic [159:0] core_hout,
    output logic [159:0] hash,
    output logic         hash_valid,
    output logic         busy
);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_PAD, S_RUN, S_WAIT, S_XTRA} state_t;

    localparam logic [159:0] H_INIT = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
    localparam logic [31:0]  MARKER = 32'h8000_0000;

    state_t         state_q, state_d;
    logic [4:0]     w_q, w_d;
    logic [31:0]    buf_q [16];
    logic [31:0]    buf_d [16];
    logic [63:0]    len_q, len_d;
    logic [159:0]   chain_q, chain_d;
    logic [159:0]   hash_q, hash_d;
    logic           final_q, final_d;
    logic           xtra_q, xtra_d;
    logic           mark_q, mark_d;
    logic           hv_q, hv_d;

    logic           accept;
    logic [31:0]    last_word;
    logic [63:0]    len_base, len_add;

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        buf_d    = buf_q;
        len_d    = len_q;
        chain_d  = chain_q;
        hash_d   = hash_q;
        final_d  = final_q;
        xtra_d   = xtra_q;
        mark_d   = mark_q;
        hv_d     = hv_q;

        in_ready = (state_q == S_IDLE) || (state_q == S_FILL);
        accept   = in_valid && in_ready;
        len_base = (state_q == S_IDLE) ? 64'd0 : len_q;
        len_add  = in_last ? {58'd0, in_nbytes, 3'd0} : 64'd32;

        case (in_nbytes)
            3'd0:    last_word = MARKER;
            3'd1:    last_word = {in_data[31:24], 24'h80_0000};
            3'd2:    last_word = {in_data[31:16], 16'h8000};
            3'd3:    last_word = {in_data[31:8], 8'h80};
            default: last_word = in_data;
        endcase

        case (state_q)
            S_IDLE, S_FILL: begin
                if (accept) begin
                    if (state_q == S_IDLE) begin
                        chain_d = H_INIT;
                        hv_d    = 1'b0;
                        final_d = 1'b0;
                        xtra_d  = 1'b0;
                        mark_d  = 1'b0;
                    end
                    len_d = len_base + len_add;
                    buf_d[w_q[3:0]] = in_last ? last_word : in_data;
                    if (in_last) begin
                        state_d = S_PAD;
                        // w now points at the slot holding the 0x80 marker (16 = deferred)
                        if (in_nbytes < 3'd4) begin
                            w_d = w_q;
                        end else if (w_q == 5'd15) begin
                            w_d    = 5'd16;
                            mark_d = 1'b1;
                        end else begin
                            buf_d[w_q[3:0] + 4'd1] = MARKER;
                            w_d = w_q + 5'd1;
                        end
                    end else begin
                        w_d = w_q + 5'd1;
                        if (w_q == 5'd15) begin
                            state_d = S_RUN;
                            final_d = 1'b0;
                            xtra_d  = 1'b0;
                        end else begin
                            state_d = S_FILL;
                        end
                    end
                end
            end
            S_PAD: begin
                for (int i = 0; i < 16; i++) begin
                    if (5'(i) > w_q) buf_d[i] = 32'd0;
                end
                if (w_q <= 5'd13) begin
                    buf_d[14] = len_q[63:32];
                    buf_d[15] = len_q[31:0];
                    final_d   = 1'b1;
                end else begin
                    final_d = 1'b0;
                    xtra_d  = 1'b1;
                end
                state_d = S_RUN;
            end
            S_RUN: state_d = S_WAIT;
            S_WAIT: begin
                if (core_done) begin
                    chain_d = core_hout;
                    if (final_q) begin
                        hash_d  = core_hout;
                        hv_d    = 1'b1;
                        final_d = 1'b0;
                        w_d     = 5'd0;
                        state_d = S_IDLE;
                    end else if (xtra_q) begin
                        state_d = S_XTRA;
                    end else begin
                        w_d     = 5'd0;
                        state_d = S_FILL;
                    end
                end
            end
            S_XTRA: begin
                for (int i = 0; i < 16; i++) buf_d[i] = 32'd0;
                buf_d[0]  = mark_q ? MARKER : 32'd0;
                buf_d[14] = len_q[63:32];
                buf_d[15] = len_q[31:0];
                final_d   = 1'b1;
                xtra_d    = 1'b0;
                mark_d    = 1'b0;
                state_d   = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            w_q     <= 5'd0;
            for (int i = 0; i < 16; i++) buf_q[i] <= 32'd0;
            len_q   <= 64'd0;
            chain_q <= H_INIT;
            hash_q  <= 160'd0;
            final_q <= 1'b0;
            xtra_q  <= 1'b0;
            mark_q  <= 1'b0;
            hv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
            chain_q <= chain_d;
            hash_q  <= hash_d;
            final_q <= final_d;
            xtra_q  <= xtra_d;
            mark_q  <= mark_d;
            hv_q    <= hv_d;
        end
    end

    always_comb begin
        core_block = '0;
        for (int i = 0; i < 16; i++) core_block[511 - 32*i -: 32] = buf_q[i];
    end

    assign core_start = (state_q == S_RUN);
    assign core_hin   = chain_q;
    assign hash       = hash_q;
    assign hash_valid = hv_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sha1_ctrl.sv
// Bench for sha1_ctrl: behavioural SHA-1 compression core plus directed
// message vectors with known digests and padded-block expectations.
module tb_sha1_ctrl;

    localparam logic [159:0] H_INIT = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
    localparam int LAT = 4;

    logic         clk, reset, in_valid, in_ready, in_last;
    logic [31:0]  in_data;
    logic [2:0]   in_nbytes;
    logic         core_start, core_done, hash_valid, busy;
    logic [511:0] core_block;
    logic [159:0] core_hin, core_hout, hash;

    sha1_ctrl dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_nbytes(in_nbytes),
        .core_start(core_start), .core_block(core_block), .core_hin(core_hin),
        .core_done(core_done), .core_hout(core_hout), .hash(hash),
        .hash_valid(hash_valid), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] sha1_comp(input logic [159:0] h, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, t;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {t[30:0], t[31]};
        end
        a = h[159:128]; b = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            t = {a[26:0], a[31:27]} + f + e + k + w[i];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
        end
        return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    // Compression core model: captures on core_start, answers LAT cycles later.
    int           starts = 0;
    logic [511:0] cap_blk;
    logic [159:0] cap_hin;
    initial begin
        logic [159:0] res;
        int cnt;
        bit pend;
        pend = 0; cnt = 0; res = '0;
        core_done = 1'b0;
        core_hout = '0;
        cap_blk = '0;
        cap_hin = '0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (core_start) begin
                starts++;
                cap_blk = core_block;
                cap_hin = core_hin;
                res  = sha1_comp(core_hin, core_block);
                cnt  = LAT;
                pend = 1;
            end else if (pend) begin
                if (cnt == 0) begin
                    core_done = 1'b1;
                    core_hout = res;
                    pend = 0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = last; in_nbytes = nb;
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) chk("in_ready_timeout", 160'd0, 160'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_hash_valid();
        int guard = 0;
        @(negedge clk);
        while (!hash_valid && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) chk("hash_valid_timeout", 160'd0, 160'd1);
    endtask

    typedef struct {
        string        name;
        int           nwords;
        logic [511:0] words;
        logic [2:0]   nb;
        logic         chk_hash;
        logic [159:0] hash;
        int           starts;
        logic [31:0]  s0, s14, s15;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [159:0] prev_hash;
        logic [511:0] wv;
        int s_base, guard;

        vecs[0] = '{"abc", 1, {32'h61626300, 480'd0}, 3'd3, 1'b1,
                    160'ha9993e364706816aba3e25717850c26c9cd0d89d, 1,
                    32'h61626380, 32'h0, 32'h18};
        vecs[1] = '{"empty", 1, 512'd0, 3'd0, 1'b1,
                    160'hda39a3ee5e6b4b0d3255bfef95601890afd80709, 1,
                    32'h80000000, 32'h0, 32'h0};
        vecs[2] = '{"a_to_z", 7, {32'h61626364, 32'h65666768, 32'h696a6b6c, 32'h6d6e6f70,
                    32'h71727374, 32'h75767778, 32'h797a0000, 288'd0}, 3'd2, 1'b1,
                    160'h32d10c7b8cf96570ca04ce37f2a19d84240d3a89, 1,
                    32'h61626364, 32'h0, 32'hd0};
        vecs[3] = '{"abcdbcde56", 14, {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c,
                    32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071,
                    64'd0}, 3'd4, 1'b1,
                    160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1, 2,
                    32'h0, 32'h0, 32'h1c0};
        vecs[4] = '{"bytes64", 16, {16{32'h61616161}}, 3'd4, 1'b0, 160'd0, 2,
                    32'h80000000, 32'h0, 32'h200};

        in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_nbytes = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_hash", hash, 0);
        chk("rst_hash_valid", hash_valid, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_block", core_block[159:0] | core_block[511:352] | core_block[351:192]
            | {128'd0, core_block[191:160]}, 0);
        chk("rst_core_hin", core_hin, H_INIT);
        reset = 1'b1;

        // Reset while waiting on the core: the late core_done must be ignored.
        send_word(32'h61626300, 1'b1, 3'd3);
        guard = 0;
        @(negedge clk);
        while (!core_start && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("mid_core_start_seen", core_start, 1);
        chk("mid_core_hin", core_hin, H_INIT);
        @(negedge clk);
        chk("mid_wait_in_ready", in_ready, 0);
        chk("mid_wait_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_hash_valid", hash_valid, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_hash", hash, 0);

        prev_hash = '0;
        for (int v = 0; v < 5; v++) begin
            s_base = starts;
            wv = vecs[v].words;
            for (int j = 0; j < vecs[v].nwords; j++) begin
                send_word(wv[511 - 32*j -: 32], (j == vecs[v].nwords - 1), vecs[v].nb);
                if (j == 0) begin
                    chk({vecs[v].name, "_hv_cleared"}, hash_valid, 0);
                    chk({vecs[v].name, "_hash_kept"}, hash, prev_hash);
                end
            end
            wait_hash_valid();
            if (vecs[v].chk_hash) chk({vecs[v].name, "_hash"}, hash, vecs[v].hash);
            chk({vecs[v].name, "_hash_valid"}, hash_valid, 1);
            chk({vecs[v].name, "_busy"}, busy, 0);
            chk({vecs[v].name, "_starts"}, 160'(starts - s_base), 160'(vecs[v].starts));
            chk({vecs[v].name, "_blk_slot0"}, cap_blk[511:480], vecs[v].s0);
            chk({vecs[v].name, "_blk_slot14"}, cap_blk[63:32], vecs[v].s14);
            chk({vecs[v].name, "_blk_slot15"}, cap_blk[31:0], vecs[v].s15);
            prev_hash = vecs[v].hash;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha1_ctrl.md
SHA1_CTRL -- requirements
Module: sha1_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-low reset; low clears all state immediately.
REQ-003 SHALL have port in_valid, input, 1: in_data word offered.
REQ-004 SHALL have port in_ready, output, 1: controller accepts word this cycle; transfer = in_valid & in_ready.
REQ-005 SHALL have port in_data, input, 32: message word, big-endian (bits 31:24 = first byte).
REQ-006 SHALL have port in_last, input, 1: word is final word of the message.
REQ-007 SHALL have port in_nbytes, input, 3: valid bytes in the last word, 0..4; ignored when in_last=0.
REQ-008 SHALL have port core_start, output, 1: one-cycle pulse launching one compression on the SHA1 core.
REQ-009 SHALL have port core_block, output, 512: padded block, word 0 in bits 511:480; stable from core_start until core_done.
REQ-010 SHALL have port core_hin, output, 160: chaining value in, H0 in bits 159:128.
REQ-011 SHALL have port core_done, input, 1: core result valid, single-cycle pulse.
REQ-012 SHALL have port core_hout, input, 160: new chaining value, feed-forward addition already applied by the core.
REQ-013 SHALL have port hash, output, 160: final digest.
REQ-014 SHALL have port hash_valid, output, 1: hash holds a completed digest.
REQ-015 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, FILL, PAD, RUN, WAIT, XTRA; in_ready=1 only in IDLE and FILL.
REQ-017 SHALL in IDLE/FILL write each accepted word to buffer slot w (0..15), increment w, and add 32 (non-last) or 8*in_nbytes (last) to a 64-bit bit-length counter.
REQ-018 SHALL, when a non-last word fills slot 15, go to RUN with pad_pending=0.
REQ-019 SHALL, on an accepted last word, mask bytes at positions >= in_nbytes to zero, put 0x80 at byte in_nbytes if in_nbytes<4, and go to PAD.
REQ-020 SHALL, when in_nbytes=4, put the 0x80 marker in the first byte of the next slot, which is slot 0 of a new block if the last word was in slot 15.
REQ-021 SHALL in PAD (one cycle) zero every slot after the marker; if slots 14-15 are free, write bit-length (high word to slot 14) and set final=1; else set final=0 and xtra=1.
REQ-022 SHALL in RUN assert core_start for exactly one cycle, then enter WAIT.
REQ-023 SHALL in WAIT, on core_done, load the chaining register from core_hout and then: if final, load hash, set hash_valid, go to IDLE; if xtra, go to XTRA; otherwise clear w, go to FILL.
REQ-024 SHALL in XTRA build a block of zeros (plus 0x80 in slot 0 if the marker was deferred per REQ-020) with bit-length in slots 14-15, set final=1, and go to RUN.
REQ-025 SHALL drive core_hin from the chaining register, initialised to 67452301 EFCDAB89 98BADCFE 10325476 C3D2E1F0 at message start.
REQ-026 SHALL treat the first word accepted in IDLE as a new message: reset chaining value and length, clear hash_valid; hash keeps its old value until overwritten.
REQ-027 SHALL ignore core_done outside WAIT.
REQ-028 SHALL support the empty message: in_last=1 with in_nbytes=0 as the first word yields a single block 0x80 followed by zeros and length 0.
REQ-029 SHALL let the length counter wrap modulo 2^64 without a flag.
REQ-030 SHALL produce core_start exactly 1 cycle after the RUN entry condition; ungated in_valid in RUN/WAIT/PAD/XTRA is stalled, not dropped.

Reset
REQ-031 SHALL, while reset is low, force the state to IDLE, w=0, length=0, chaining register=H0, final=xtra=0, core_start=0, hash=0, hash_valid=0, busy=0, and core_block=0.
REQ-032 SHALL, on reset assertion mid-message (any state), abandon the message; a later core_done SHALL be ignored.

Verification
REQ-033 SHALL pass: "abc" as one word, in_last, in_nbytes=3 -> single core_start, hash=a9993e364706816aba3e25717850c26c9cd0d89d.
REQ-034 SHALL pass: empty message (REQ-028) -> hash=da39a3ee5e6b4b0d3255bfef95601890afd80709.
REQ-035 SHALL pass: "a".."z" (7 words, last in_nbytes=2) -> core_block ends in 0x000000d0, hash=32d10c7b8cf96570ca04ce37f2a19d84240d3a89.
REQ-036 SHALL pass: 56-byte "abcdbcdecdefdefg...nopq" -> two core_start pulses (second via XTRA), hash=84983e441c3bd26ebaae4aa1f95129e5e54670f1.
REQ-037 SHALL pass: 64-byte message, last word in_nbytes=4 in slot 15 -> XTRA block slot 0 = 0x80000000, slots 14-15 = 0x00000000_00000200.
REQ-038 SHALL pass: reset pulsed low while in WAIT, then core_done -> hash_valid stays 0 and "abc" afterwards gives the REQ-033 digest.
